// File: rtl/bus_mem_responder.sv
// Memory-side responder for the CPU bus: boot-loaded word RAM, one memory-mapped
// output register, and a sticky flag for accesses that hit neither.
module bus_mem_responder #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] IO_ADDR   = 32'hFFFF_FFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        rw,
    output logic [31:0] rdata,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        loading,
    output logic [31:0] io_out,
    output logic        io_strobe,
    output logic        err
);

    // state   | meaning
    // ST_LOAD | CPU held in reset, boot words written to RAM in order from index 0
    // ST_RUN  | CPU bus served; stays here until reset
    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t                 state, state_nxt;
    logic [ADDR_BITS-1:0]   load_cnt, load_cnt_nxt;
    logic                   load_accept;
    logic                   run;
    logic                   in_range;
    logic                   is_io;
    logic                   ram_we;
    logic [ADDR_BITS-1:0]   ram_idx;
    logic [31:0]            ram_wdata;
    logic [31:0]            mem [DEPTH];

    assign run      = (state == ST_RUN);
    assign in_range = (address[31:ADDR_BITS] == '0);
    assign is_io    = (address == IO_ADDR);

    always_comb begin
        state_nxt    = state;
        load_cnt_nxt = load_cnt;
        loading      = 1'b0;
        load_ready   = 1'b0;
        load_accept  = 1'b0;
        case (state)
            ST_LOAD: begin
                loading    = 1'b1;
                load_ready = 1'b1;
                if (load_valid) begin
                    load_accept  = 1'b1;
                    load_cnt_nxt = load_cnt + 1'b1;
                    // A full RAM ends the load even without load_last.
                    if (load_last || load_cnt == {ADDR_BITS{1'b1}})
                        state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // Boot loader and CPU share the single RAM write port; the FSM keeps them exclusive.
    always_comb begin
        ram_we    = 1'b0;
        ram_idx   = address[ADDR_BITS-1:0];
        ram_wdata = wdata;
        if (!reset) begin
            if (load_accept) begin
                ram_we    = 1'b1;
                ram_idx   = load_cnt;
                ram_wdata = load_data;
            end else if (run && !rw && in_range) begin
                ram_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we)
            mem[ram_idx] <= ram_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_LOAD;
            load_cnt  <= '0;
            rdata     <= '0;
            io_out    <= '0;
            io_strobe <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            load_cnt  <= load_cnt_nxt;
            io_strobe <= 1'b0;
            if (!run) begin
                rdata <= '0;
            end else if (rw) begin
                if (in_range) begin
                    rdata <= mem[address[ADDR_BITS-1:0]];
                end else if (is_io) begin
                    rdata <= io_out;
                end else begin
                    rdata <= '0;
                    err   <= 1'b1;
                end
            end else begin
                if (in_range) begin
                    // RAM write handled on the shared port above
                end else if (is_io) begin
                    io_out    <= wdata;
                    io_strobe <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
